lb_conv_engine: RTL

Parametrised streaming 2-D convolution engine with internal line buffers. It accepts one raster-ordered unsigned pixel per handshake and produces one signed K×K weighted sum per valid window position. Kernel size, frame size, data and coefficient widths, and runtime-loadable coefficients are all configurable. Valid/ready backpressure is supported on both sides. It sits between the pixel source (frame memory reader) and downstream result consumers, and supersedes the fixed 3×3, fixed-strobe line-buffer convolver.

---
 rtl/lb_conv_pkg.sv | 14 +
 rtl/lb_conv_engine_row_delay.sv | 34 +++
 rtl/lb_conv_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lb_conv_pkg.sv
// Shared state type and sizing helpers for the line-buffer convolution engine.
package lb_conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int calc_ow(input int dw, input int cw, input int k);
    return dw + cw + 1 + $clog2(k * k);
  endfunction

  function automatic int results_per_frame(input int img_w, input int img_h, input int k);
    return (img_w - k + 1) * (img_h - k + 1);
  endfunction

endpackage

// File: rtl/lb_conv_engine_row_delay.sv
// One-row circular delay line: dout is the sample written DEPTH enables earlier.
module lb_row_delay #(
  parameter int DW    = 16,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  end

  // Contents are never cleared; validity comes from the frame counters.
  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end

  assign dout = mem[ptr];

endmodule

// File: rtl/lb_conv_engine.sv
// Streaming KxK convolution: row delay lines feed a window, then a registered
// multiply stage and a registered adder tree drive the result port.
//   state | meaning
//   IDLE  | waiting for start; coefficient writes accepted
//   RUN   | accepting IMG_W*IMG_H pixels
//   DRAIN | flushing the pipeline until the out_last handshake
//   DONE  | single-cycle done pulse
module lb_conv_engine
  import lb_conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int OW    = calc_ow(DW, CW, K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   coef_we,
  input  logic [$clog2(K*K)-1:0] coef_addr,
  input  logic signed [CW-1:0]   coef_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OW-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int NT = K * K;
  localparam int PW = DW + CW + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_MIN  = XW'(K - 1);
  localparam logic [YW-1:0] ROW_MIN  = YW'(K - 1);

  state_t state, state_nxt;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic signed [CW-1:0] coef [NT];
  logic [K-1:0][K-1:0][DW-1:0] win, win_nxt;
  logic [K-1:0][DW-1:0] tap;
  logic signed [PW-1:0] prod [NT];
  logic signed [OW-1:0] sum;
  logic p_vld, p_last;
  logic adv, accept, frame_end, win_ok;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && adv;
  assign accept    = in_valid && in_ready;
  assign frame_end = (col == COL_LAST) && (row == ROW_LAST);
  assign win_ok    = (col >= COL_MIN) && (row >= ROW_MIN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && frame_end) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) coef[i] <= CW'(1);
    end else if (state == IDLE && coef_we && int'(coef_addr) < NT) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Bottom window row is the live pixel; each delay line supplies the row above.
  assign tap[K-1] = in_data;
  for (genvar i = 0; i < K - 1; i++) begin : g_line
    lb_row_delay #(.DW(DW), .DEPTH(IMG_W)) u_line (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (tap[K-1-i]),
      .dout (tap[K-2-i])
    );
  end

  always_comb begin
    win_nxt = win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = tap[r];
    end
  end

  // Multiply directly from the post-shift window so the result is two stages after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod[r*K+c] <= PW'($signed({1'b0, win_nxt[r][c]})) * PW'(coef[r*K+c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else if (adv) begin
      p_vld  <= accept && win_ok;
      p_last <= accept && frame_end;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + OW'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= p_vld;
      out_last  <= p_last;
      if (p_vld) out_data <= sum;
    end
  end

endmodule
